fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Consumer-side buffer for the instruction stream produced by the program counter and instruction memory.
- Captures {PC, instruction} pairs from the fetch stage and presents them in order to decode through a valid/ready handshake.
- Drives PCWrite back to the program counter's Write input, so the PC stalls when the queue is full.
- Flush discards all entries on a taken branch or jump.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 32, PC width.
- DW, 32, instruction width.
- CW, $clog2(DEPTH)+1, width of the Count output (3 at the default DEPTH).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-low reset. Sampled on the Clk rising edge; 0 = reset.
- InPC  input  AW  PC of the incoming instruction (the program counter's Result).
- InInstr  input  DW  instruction word fetched at InPC.
- InValid  input  1  InPC/InInstr are valid this cycle.
- PCWrite  output  1  queue can accept; connects to the program counter's Write input.
- OutPC  output  AW  PC of the head entry.
- OutInstr  output  DW  instruction of the head entry.
- OutValid  output  1  head entry is valid.
- OutReady  input  1  decode accepts the head entry this cycle.
- Flush  input  1  discard all entries.
- Count  output  CW  number of occupied entries.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {AW PC, DW instr}.
  - Read pointer (rd_ptr) and write pointer (wr_ptr) wrap modulo DEPTH.
  - Occupancy counter holds 0..DEPTH.
- Full = (Count == DEPTH); Empty = (Count == 0).
- PCWrite = !Full. Combinational from registered state only; no dependence on OutReady.
- Push = InValid && !Full && !Flush.
  - Writes {InPC, InInstr} at wr_ptr; wr_ptr increments.
  - InValid while Full: the input is ignored and not stored. The upstream PC is already stalled via PCWrite.
- Pop = OutValid && OutReady && !Flush.
  - rd_ptr increments.
  - OutReady while empty: no effect.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (neither full nor empty): unchanged, both pointers advance.
- Full plus pop in the same cycle: the pop takes effect and no push occurs. PCWrite rises the following cycle.
- Latency: an entry pushed at edge N is visible on OutPC/OutInstr with OutValid=1 after edge N. There is no combinational bypass from In* to Out*.
- Output data:
  - OutValid = !Empty.
  - When OutValid=1, OutPC/OutInstr = head entry at rd_ptr.
  - When Empty, OutPC and OutInstr are 0.
- Ordering: strict FIFO; entries leave in push order.
- Flush (Reset high, Flush=1 at an edge):
  - rd_ptr, wr_ptr and Count become 0.
  - Any same-cycle push and pop is discarded.
  - Next cycle: OutValid=0, PCWrite=1.
  - Storage contents need not be cleared.
- Priority: Reset > Flush > push/pop.
- Reset (Reset=0 at an edge):
  - Pointers become 0, Count=0, OutValid=0, OutPC=0, OutInstr=0, PCWrite=1.
  - Applies mid-operation regardless of other inputs.
- Initial state: pointers and Count are 0 before the first reset.
- Arithmetic: pointer increments wrap without overflow into Count; Count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset=0 for 2 cycles with InValid=1 -> OutValid=0, Count=0, PCWrite=1, OutPC=0, OutInstr=0.
- Push PC 0x00,0x04,0x08,0x0C (instr 0xA0..0xA3) with OutReady=0 -> Count reaches 4 and PCWrite=0. A fifth push of 0x10 is ignored. Then OutReady=1 for 4 cycles -> output order 0x00,0x04,0x08,0x0C, then OutValid=0.
- With Count=2, InValid=1 and OutReady=1 for 6 cycles -> Count stays 2; pointers wrap past DEPTH; output order matches push order.
- Full queue, OutReady=1, InValid=1 in the same cycle -> one pop, no push, Count=3, and PCWrite=1 the next cycle.
- Count=3, Flush=1 with InValid=1 and OutReady=1 -> next cycle Count=0, OutValid=0, PCWrite=1. The next push of PC 0x40 appears at the head one cycle later.
- Count=2, Reset=0 together with Flush=1 and InValid=1 -> all outputs take their reset values. After Reset=1, a push of 0x80 gives OutPC=0x80 and Count=1.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: buffers {PC, instruction} pairs between fetch and decode, stalling the
// program counter through PCWrite when full. Flush drops everything on a redirect.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [AW-1:0] InPC,
  input  logic [DW-1:0] InInstr,
  input  logic          InValid,
  output logic          PCWrite,
  output logic [AW-1:0] OutPC,
  output logic [DW-1:0] OutInstr,
  output logic          OutValid,
  input  logic          OutReady,
  input  logic          Flush,
  output logic [CW-1:0] Count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW+DW-1:0] r_mem [DEPTH];

  // Power-up values so the queue reads as empty even before the first reset edge.
  logic [PW-1:0] r_rd_ptr = '0;
  logic [PW-1:0] r_wr_ptr = '0;
  logic [CW-1:0] r_count  = '0;

  logic [PW-1:0] w_rd_ptr_d;
  logic [PW-1:0] w_wr_ptr_d;
  logic [CW-1:0] w_count_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full queue never pushes, so pop-while-full frees a slot only for the next cycle.
  assign w_push = InValid && !w_full && !Flush;
  assign w_pop  = !w_empty && OutReady && !Flush;

  always_comb begin
    w_rd_ptr_d = r_rd_ptr;
    w_wr_ptr_d = r_wr_ptr;
    w_count_d  = r_count;
    if (Flush) begin
      w_rd_ptr_d = '0;
      w_wr_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_d = r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        w_rd_ptr_d = r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   w_count_d = r_count + 1'b1;
        2'b01:   w_count_d = r_count - 1'b1;
        default: w_count_d = r_count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_d;
      r_wr_ptr <= w_wr_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // Storage is never cleared; occupancy alone decides what is visible.
  always_ff @(posedge Clk) begin
    if (Reset && w_push) begin
      r_mem[r_wr_ptr] <= {InPC, InInstr};
    end
  end

  always_comb begin
    PCWrite  = !w_full;
    OutValid = !w_empty;
    Count    = r_count;
    OutPC    = '0;
    OutInstr = '0;
    if (!w_empty) begin
      {OutPC, OutInstr} = r_mem[r_rd_ptr];
    end
  end

endmodule
